// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO geometry and the count-width helper shared by the FIFO top and its RAM instantiation
package fifo_pkg;
  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 13;
  localparam int FIFO_RAM_DEPTH = 5000;
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_controller_if.sv
// fifo_controller_if: push/pop, status and dual-port RAM signals of the FIFO controller
// slave: controller side (push/pop requests and ram_rdata in; pop data, flags, count and RAM write/read address out)
// master: producer/consumer/RAM side; overflow/underflow exist only with FIFO_ERR_FLAGS_EN
interface fifo_controller_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
  modport slave (input wr_en, wr_data, rd_en, ram_rdata,
                 output rd_data, rd_valid, full, empty, almost_full, count,
                 ram_waddr, ram_wdata, ram_we, ram_raddr, overflow, underflow);
  modport master (output wr_en, wr_data, rd_en, ram_rdata,
                  input rd_data, rd_valid, full, empty, almost_full, count,
                  ram_waddr, ram_wdata, ram_we, ram_raddr, overflow, underflow);
`else
  modport slave (input wr_en, wr_data, rd_en, ram_rdata,
                 output rd_data, rd_valid, full, empty, almost_full, count,
                 ram_waddr, ram_wdata, ram_we, ram_raddr);
  modport master (output wr_en, wr_data, rd_en, ram_rdata,
                  input rd_data, rd_valid, full, empty, almost_full, count,
                  ram_waddr, ram_wdata, ram_we, ram_raddr);
`endif
endinterface

// File: rtl/fifo_ptr_wrap.sv
// fifo_ptr_wrap: pointer that advances on inc and wraps from RAM_DEPTH-1 to 0 (any depth)
// ports: clk, rst (sync, active-high), inc (advance), ptr (current value)
module fifo_ptr_wrap #(
  parameter int ADDR_WIDTH = 13,
  parameter int RAM_DEPTH = 5000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  always_comb ptr_d = !inc ? ptr_q : ptr_q == ADDR_WIDTH'(RAM_DEPTH - 1) ? '0 : ptr_q + ADDR_WIDTH'(1);
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/fifo_controller.sv
// fifo_controller: synchronous FIFO control (pointers, count, flags) in front of an async-read dual-port RAM
// ports: clk, rst (sync, active-high), bus (fifo_controller_if.slave: push/pop, rd_data/rd_valid, flags, count, RAM port)
// FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs on bus
module fifo_controller
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int RAM_DEPTH = FIFO_RAM_DEPTH,
  parameter int ALMOST_FULL_TH = 4900
) (
  input logic               clk,
  input logic               rst,
  fifo_controller_if.slave  bus
);
  localparam int CW = cnt_width(ADDR_WIDTH);
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;
  logic                  push_ok, pop_ok;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  // requests in the reset cycle are ignored so the RAM is not written either
  always_comb begin
    pop_ok = !rst && bus.rd_en && !empty_q;
    push_ok = !rst && bus.wr_en && (!full_q || pop_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    empty_d = count_d == '0;
    full_d = count_d == CW'(RAM_DEPTH);
    af_d = count_d >= CW'(ALMOST_FULL_TH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      af_q <= 1'b0;
      rd_data_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
      full_q <= full_d;
      af_q <= af_d;
      rd_data_q <= pop_ok ? bus.ram_rdata : rd_data_q;
      rd_valid_q <= pop_ok;
    end
  end
  fifo_ptr_wrap #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_wr_ptr (
    .clk(clk), .rst(rst), .inc(push_ok), .ptr(wr_ptr)
  );
  fifo_ptr_wrap #(.ADDR_WIDTH(ADDR_WIDTH), .RAM_DEPTH(RAM_DEPTH)) u_rd_ptr (
    .clk(clk), .rst(rst), .inc(pop_ok), .ptr(rd_ptr)
  );
  assign bus.rd_data = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.full = full_q;
  assign bus.empty = empty_q;
  assign bus.almost_full = af_q;
  assign bus.count = count_q;
  assign bus.ram_waddr = wr_ptr;
  assign bus.ram_wdata = bus.wr_data;
  assign bus.ram_we = push_ok;
  assign bus.ram_raddr = rd_ptr;
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (bus.wr_en && full_q && !pop_ok);
      underflow_q <= underflow_q | (bus.rd_en && empty_q);
    end
  end
  assign bus.overflow = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_controller.sv
// tb_fifo_controller: scoreboard bench for fifo_controller with a behavioural async-read RAM
module tb_fifo_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] mem [5000];
  bit addr_x = 1'b0;

  fifo_controller_if #(.DATA_WIDTH(8), .ADDR_WIDTH(13)) bus ();

  fifo_controller #(.DATA_WIDTH(8), .ADDR_WIDTH(13), .RAM_DEPTH(5000), .ALMOST_FULL_TH(4900)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
  assign bus.ram_rdata = mem[bus.ram_raddr];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if ($isunknown(bus.ram_raddr) || $isunknown(bus.ram_waddr)) addr_x = 1'b1;
    if (!rst && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected got=%0h exp=none", bus.rd_data);
      end else chk("rd_data", {24'h0, bus.rd_data}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic step(input logic we, input logic [7:0] wd, input logic re);
    bit pe, pf, pop, push;
    pe = mq.size() == 0;
    pf = mq.size() == 5000;
    pop = re && !pe;
    push = we && (!pf || pop);
    bus.wr_en = we;
    bus.wr_data = wd;
    bus.rd_en = re;
    if (pop) exp_q.push_back(mq.pop_front());
    if (push) mq.push_back(wd);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 5000; i++) mem[i] = 8'h00;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_af", 32'(bus.almost_full), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_underflow", 32'(bus.underflow), 0);
`endif
    rst = 1'b0;
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    chk("basic_count", 32'(bus.count), 3);
    chk("basic_empty", 32'(bus.empty), 0);
    step(0, 8'h00, 1);
    chk("basic_rd0", 32'(bus.rd_data), 32'h11);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    chk("basic_rd2", 32'(bus.rd_data), 32'h33);
    chk("basic_valid", 32'(bus.rd_valid), 1);
    chk("basic_empty_after", 32'(bus.empty), 1);
    step(0, 8'h00, 0);
    chk("basic_valid_drop", 32'(bus.rd_valid), 0);
    for (int i = 0; i < 5000; i++) begin
      step(1, 8'(i), 0);
      if (i == 4898) chk("af_4899", 32'(bus.almost_full), 0);
      if (i == 4899) chk("af_4900", 32'(bus.almost_full), 1);
      if (i == 4998) chk("full_4999", 32'(bus.full), 0);
    end
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 5000);
    step(1, 8'hEE, 0);
    chk("drop_count", 32'(bus.count), 5000);
    chk("drop_full", 32'(bus.full), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow_set", 32'(bus.overflow), 1);
`endif
    step(1, 8'hAA, 1);
    chk("full_rw_count", 32'(bus.count), 5000);
    chk("full_rw_rd", 32'(bus.rd_data), 32'h00);
    chk("full_rw_full", 32'(bus.full), 1);
    for (int i = 0; i < 5000; i++) step(0, 8'h00, 1);
    chk("drain_last", 32'(bus.rd_data), 32'hAA);
    chk("drain_empty", 32'(bus.empty), 1);
    for (int i = 0; i < 10; i++) step(1, 8'(i) ^ 8'h5A, 0);
    for (int i = 10; i < 6000; i++) step(1, 8'(i) ^ 8'h5A, 1);
    chk("stream_count", 32'(bus.count), 10);
    for (int i = 0; i < 10; i++) step(0, 8'h00, 1);
    chk("stream_last", 32'(bus.rd_data), 32'(8'(5999) ^ 8'h5A));
    chk("stream_addr_x", 32'(addr_x), 0);
    step(1, 8'h5C, 1);
    chk("empty_rw_valid", 32'(bus.rd_valid), 0);
    chk("empty_rw_count", 32'(bus.count), 1);
    step(0, 8'h00, 1);
    chk("empty_rw_rd", 32'(bus.rd_data), 32'h5C);
    chk("empty_rw_valid2", 32'(bus.rd_valid), 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("underflow_set", 32'(bus.underflow), 1);
`endif
    for (int i = 0; i < 7; i++) step(1, 8'(i + 1), 0);
    chk("pre_rst_count", 32'(bus.count), 7);
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h77;
    #1;
    chk("rst_cycle_we", 32'(bus.ram_we), 0);
    @(posedge clk);
    #1;
    mq.delete();
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_valid", 32'(bus.rd_valid), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mid_rst_overflow", 32'(bus.overflow), 0);
`endif
    rst = 1'b0;
    bus.wr_en = 1'b0;
    step(0, 8'h00, 1);
    chk("post_rst_valid", 32'(bus.rd_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
